wb_regfile: RTL and testbench
=============================

Name: wb_regfile

Overview:
Writeback-end consumer of the MEM/WB pipeline register outputs: selects the writeback data (memory vs ALU), commits it to a 32x32 general-purpose register file, and serves the ID stage's two read ports. Same-cycle write-to-read bypass removes the WB->ID hazard. A retire counter and debug read port support verification.

Parameters:
DATA_W, 32, register/data width
ADDR_W, 5, register address width (2**ADDR_W registers)
CNT_W, 32, width of writeback retire counter

Ports:
clk_i  input  1  clock, all state updates on rising edge
rst_i  input  1  synchronous active-high reset
writeBack_i  input  1  register write enable from MEM/WB
memtoReg_i  input  1  1 = write memReadData_i, 0 = write ALUresult_i
memReadData_i  input  DATA_W  load data from MEM/WB
ALUresult_i  input  DATA_W  ALU result from MEM/WB
regDstAddr_i  input  ADDR_W  destination register
rs_addr_i  input  ADDR_W  read port A address (ID stage)
rt_addr_i  input  ADDR_W  read port B address (ID stage)
rs_data_o  output  DATA_W  read port A data
rt_data_o  output  DATA_W  read port B data
wb_data_o  output  DATA_W  selected writeback data (to EX forwarding mux)
dbg_addr_i  input  ADDR_W  debug read address
dbg_data_o  output  DATA_W  debug read data (raw array, no bypass)
retire_cnt_o  output  CNT_W  number of committed non-r0 writes since reset

Behaviour:
- Clock clk_i; reset rst_i synchronous, active-high; sampled only at rising edge.
- Reset: all 32 registers <= 0, retire_cnt_o <= 0. rst_i overrides a simultaneous write (write dropped, counter not incremented).
- wb_data_o = memtoReg_i ? memReadData_i : ALUresult_i; purely combinational, independent of writeBack_i.
- Commit: on rising edge with !rst_i && writeBack_i && regDstAddr_i != 0: reg[regDstAddr_i] <= wb_data_o; retire_cnt_o <= retire_cnt_o + 1 (wraps modulo 2**CNT_W, no saturation).
- Register 0: always reads 0; writes to r0 ignored and not counted.
- Read ports combinational (0-cycle latency):
  - addr == 0 -> 0.
  - else if writeBack_i && regDstAddr_i == addr -> wb_data_o (write-first bypass, same cycle).
  - else reg[addr].
- Both read ports may address the same register, including the one being written; both return the bypassed value.
- dbg_data_o = reg[dbg_addr_i] (committed state only, no bypass; r0 reads 0).
- During rst_i high: read ports still decode combinationally; bypass remains active (data visible, but not committed).
- Outputs after reset release: rs/rt/dbg data = 0 unless bypassed; retire_cnt_o = 0.
- No X propagation: array initialised only via reset; bench must reset before use.

Decomposition:
- Shared package: DATA_W/ADDR_W defaults, REG_ZERO constant (5'd0), WB_SEL_MEM/WB_SEL_ALU encodings for memtoReg.
- One natural sub-module: wb_mux (2:1 DATA_W writeback select), reused by the EX forwarding path. Array, bypass and counter stay in wb_regfile.

Test Plan:
- Reset then read all 32 addresses on rs/rt/dbg -> all 0, retire_cnt_o = 0.
- writeBack=1, memtoReg=0, ALUresult=0x0000_1234, dst=5, rs_addr=5 same cycle -> rs_data_o = 0x1234 (bypass), dbg(5) = 0 before edge, 0x1234 after; retire_cnt_o = 1.
- writeBack=1, memtoReg=1, memReadData=0xDEAD_BEEF, ALUresult=0x1, dst=7 -> wb_data_o = 0xDEADBEEF, reg7 = 0xDEADBEEF; memtoReg=0 next write gives 0x1.
- Write 0xFFFF_FFFF to dst=0 with rs_addr=rt_addr=0 -> rs/rt = 0, dbg(0) = 0, retire_cnt_o unchanged.
- writeBack=0, dst=9, ALUresult=0x55 with rt_addr=9 holding 0xAA -> rt_data_o = 0xAA, reg9 unchanged, no count.
- Populate r3=0x33, assert rst_i together with write dst=3 data 0x99 -> after edge reg3 = 0, retire_cnt_o = 0.

Source files
------------

// File: rtl/wb_regfile_pkg.sv
// Shared constants for the writeback / register-file slice.
// Default widths, the hard-wired zero register index and the memtoReg select encodings.
package wb_regfile_pkg;

   localparam int unsigned DEF_DATA_W = 32;
   localparam int unsigned DEF_ADDR_W = 5;
   localparam int unsigned DEF_CNT_W  = 32;

   localparam logic [4:0] REG_ZERO = 5'd0;

   localparam logic WB_SEL_MEM = 1'b1;
   localparam logic WB_SEL_ALU = 1'b0;

endpackage : wb_regfile_pkg

// File: rtl/wb_regfile_wb_mux.sv
// 2:1 writeback data select (load data vs ALU result).
// The EX forwarding path also instantiates it, so it stays a standalone module.
module wb_regfile_wb_mux
   import wb_regfile_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W
) (
   input  logic              sel_i,
   input  logic [DATA_W-1:0] mem_data_i,
   input  logic [DATA_W-1:0] alu_data_i,
   output logic [DATA_W-1:0] data_o
);

   assign data_o = (sel_i == WB_SEL_MEM) ? mem_data_i : alu_data_i;

endmodule : wb_regfile_wb_mux

// File: rtl/wb_regfile.sv
// Writeback stage register file: selects writeback data, commits it to the GPR array,
// and serves two bypassed ID read ports, a raw debug port and a retire counter.
module wb_regfile
   import wb_regfile_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned ADDR_W = DEF_ADDR_W,
   parameter int unsigned CNT_W  = DEF_CNT_W
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              writeBack_i,
   input  logic              memtoReg_i,
   input  logic [DATA_W-1:0] memReadData_i,
   input  logic [DATA_W-1:0] ALUresult_i,
   input  logic [ADDR_W-1:0] regDstAddr_i,
   input  logic [ADDR_W-1:0] rs_addr_i,
   input  logic [ADDR_W-1:0] rt_addr_i,
   output logic [DATA_W-1:0] rs_data_o,
   output logic [DATA_W-1:0] rt_data_o,
   output logic [DATA_W-1:0] wb_data_o,
   input  logic [ADDR_W-1:0] dbg_addr_i,
   output logic [DATA_W-1:0] dbg_data_o,
   output logic [CNT_W-1:0]  retire_cnt_o
);

   localparam int unsigned NumRegs = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] RegZero = ADDR_W'(REG_ZERO);

   logic [DATA_W-1:0] regs_q [NumRegs];
   logic [CNT_W-1:0]  retire_cnt_q, retire_cnt_d;
   logic [DATA_W-1:0] wb_data;
   logic              commit;

   wb_regfile_wb_mux #(
      .DATA_W (DATA_W)
   ) u_wb_mux (
      .sel_i      (memtoReg_i),
      .mem_data_i (memReadData_i),
      .alu_data_i (ALUresult_i),
      .data_o     (wb_data)
   );

   assign wb_data_o    = wb_data;
   assign commit       = writeBack_i && (regDstAddr_i != RegZero);
   assign retire_cnt_d = retire_cnt_q + CNT_W'(1);
   assign retire_cnt_o = retire_cnt_q;

   // Write-first bypass: the value being written this cycle is visible to ID immediately,
   // even while rst_i is high (it just never commits).
   always_comb begin
      rs_data_o = regs_q[rs_addr_i];
      if (rs_addr_i == RegZero) begin
         rs_data_o = '0;
      end else if (writeBack_i && (regDstAddr_i == rs_addr_i)) begin
         rs_data_o = wb_data;
      end
   end

   always_comb begin
      rt_data_o = regs_q[rt_addr_i];
      if (rt_addr_i == RegZero) begin
         rt_data_o = '0;
      end else if (writeBack_i && (regDstAddr_i == rt_addr_i)) begin
         rt_data_o = wb_data;
      end
   end

   always_comb begin
      dbg_data_o = regs_q[dbg_addr_i];
      if (dbg_addr_i == RegZero) begin
         dbg_data_o = '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < NumRegs; i++) begin
            regs_q[i] <= '0;
         end
         retire_cnt_q <= '0;
      end else if (commit) begin
         regs_q[regDstAddr_i] <= wb_data;
         retire_cnt_q         <= retire_cnt_d;
      end
   end

endmodule : wb_regfile

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed steps then randomized traffic,
// compared against an array-based reference model of the architectural register file.
module tb_wb_regfile;

   logic        clk;
   logic        rst;
   logic        we;
   logic        mt;
   logic [31:0] mem_data;
   logic [31:0] alu_data;
   logic [4:0]  dst;
   logic [4:0]  rs_addr;
   logic [4:0]  rt_addr;
   logic [31:0] rs_data;
   logic [31:0] rt_data;
   logic [31:0] wb_data;
   logic [4:0]  dbg_addr;
   logic [31:0] dbg_data;
   logic [31:0] retire_cnt;

   logic [31:0] model_regs [32];
   logic [31:0] model_cnt;

   int n_checks = 0;
   int n_pass   = 0;

   wb_regfile u_dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .writeBack_i   (we),
      .memtoReg_i    (mt),
      .memReadData_i (mem_data),
      .ALUresult_i   (alu_data),
      .regDstAddr_i  (dst),
      .rs_addr_i     (rs_addr),
      .rt_addr_i     (rt_addr),
      .rs_data_o     (rs_data),
      .rt_data_o     (rt_data),
      .wb_data_o     (wb_data),
      .dbg_addr_i    (dbg_addr),
      .dbg_data_o    (dbg_data),
      .retire_cnt_o  (retire_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   function automatic logic [31:0] exp_wb();
      return mt ? mem_data : alu_data;
   endfunction

   function automatic logic [31:0] exp_read(input logic [4:0] a);
      if (a == 5'd0) return 32'h0;
      if (we && (dst == a)) return exp_wb();
      return model_regs[a];
   endfunction

   // One pipeline cycle: drive, check combinational outputs, clock, update model, check state.
   task automatic step(input logic r, input logic w, input logic m, input logic [31:0] md,
                       input logic [31:0] ad, input logic [4:0] d, input logic [4:0] ra,
                       input logic [4:0] rb, input logic [4:0] dba);
      @(negedge clk);
      rst = r; we = w; mt = m; mem_data = md; alu_data = ad;
      dst = d; rs_addr = ra; rt_addr = rb; dbg_addr = dba;
      #1;
      check("wb_data", wb_data, exp_wb());
      check("rs_data", rs_data, exp_read(ra));
      check("rt_data", rt_data, exp_read(rb));
      check("dbg_pre", dbg_data, (dba == 5'd0) ? 32'h0 : model_regs[dba]);
      check("cnt_pre", retire_cnt, model_cnt);
      @(posedge clk);
      if (r) begin
         for (int i = 0; i < 32; i++) model_regs[i] = 32'h0;
         model_cnt = 32'h0;
      end else if (w && (d != 5'd0)) begin
         model_regs[d] = m ? md : ad;
         model_cnt     = model_cnt + 32'd1;
      end
      #1;
      check("dbg_post", dbg_data, (dba == 5'd0) ? 32'h0 : model_regs[dba]);
      check("cnt_post", retire_cnt, model_cnt);
   endtask

   initial begin
      logic [31:0] rd, ra;
      rst = 1'b1; we = 1'b0; mt = 1'b0; mem_data = '0; alu_data = '0;
      dst = '0; rs_addr = '0; rt_addr = '0; dbg_addr = '0;
      for (int i = 0; i < 32; i++) model_regs[i] = 32'h0;
      model_cnt = 32'h0;

      step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 5'd0);
      step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 5'd0);

      // All addresses read zero after reset.
      for (int i = 0; i < 32; i++) begin
         step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'(i), 5'(31 - i), 5'(i));
      end

      // Bypass on rs, debug sees the commit only after the edge.
      step(1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_1234, 5'd5, 5'd5, 5'd0, 5'd5);
      check("r5_committed", dbg_data, 32'h0000_1234);
      check("cnt_one", retire_cnt, 32'd1);

      // Memory select, then ALU select to the same register.
      step(1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'h1, 5'd7, 5'd7, 5'd7, 5'd7);
      check("r7_mem", dbg_data, 32'hDEAD_BEEF);
      step(1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF, 32'h1, 5'd7, 5'd7, 5'd5, 5'd7);
      check("r7_alu", dbg_data, 32'h1);

      // Write to r0 ignored and not counted.
      step(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd0, 5'd0);
      check("cnt_r0", retire_cnt, 32'd3);

      // writeBack low: no bypass, no commit.
      step(1'b0, 1'b1, 1'b0, 32'h0, 32'hAA, 5'd9, 5'd0, 5'd9, 5'd9);
      step(1'b0, 1'b0, 1'b0, 32'h0, 32'h55, 5'd9, 5'd9, 5'd9, 5'd9);
      check("r9_kept", dbg_data, 32'hAA);
      check("cnt_nowb", retire_cnt, 32'd4);

      // Reset wins over a simultaneous write.
      step(1'b0, 1'b1, 1'b0, 32'h0, 32'h33, 5'd3, 5'd3, 5'd3, 5'd3);
      step(1'b1, 1'b1, 1'b0, 32'h0, 32'h99, 5'd3, 5'd3, 5'd3, 5'd3);
      check("r3_reset", dbg_data, 32'h0);
      check("cnt_reset", retire_cnt, 32'd0);

      // Randomized traffic.
      for (int n = 0; n < 400; n++) begin
         logic [4:0] d, a, b, g;
         d  = 5'($urandom_range(0, 31));
         a  = ($urandom_range(0, 3) == 0) ? d : 5'($urandom_range(0, 31));
         b  = ($urandom_range(0, 3) == 0) ? d : 5'($urandom_range(0, 31));
         g  = ($urandom_range(0, 1) == 0) ? d : 5'($urandom_range(0, 31));
         rd = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFF : $urandom;
         ra = $urandom;
         step(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0),
              1'($urandom_range(0, 1)), rd, ra, d, a, b, g);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_wb_regfile
